// File: rtl/bram_req_responder.sv
// Request/response front end for a single-port BRAM with 1-cycle synchronous read.
// Optional power-up clear sweep is built when MEM_CLEAR_EN is defined.
module bram_req_responder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int RESP_DEPTH = 2
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy
);

  localparam int IDX_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = RESP_DEPTH[CNT_W:0];

  logic [CNT_W-1:0] count;
  logic             pending;
  logic [DATA_W-1:0] fifo_q [RESP_DEPTH];
  logic [CNT_W:0]   occ;
  logic [CNT_W-1:0] wr_pos;
  logic             pop;
  logic             push;
  logic             accept;
  logic             ready_st;
  logic             clearing;

  assign pop        = resp_valid & resp_ready;
  assign push       = pending;
  assign occ        = {1'b0, count} + {{CNT_W{1'b0}}, pending};
  assign req_ready  = rsta_n & ready_st & ((occ < DEPTH_L) | pop);
  assign accept     = req_valid & req_ready;
  assign resp_valid = (count != '0);
  assign resp_data  = fifo_q[0];
  assign busy       = clearing;
  // A push lands just behind the surviving entries, after any same-edge pop shift.
  assign wr_pos     = count - {{(CNT_W-1){1'b0}}, pop};

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      count   <= '0;
      pending <= 1'b0;
      for (int i = 0; i < RESP_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      pending <= accept & ~req_we;
      count   <= count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
      if (pop) begin
        for (int i = 0; i < RESP_DEPTH-1; i++) fifo_q[i] <= fifo_q[i+1];
      end
      if (push) fifo_q[wr_pos[IDX_W-1:0]] <= bram_dout;
    end
  end

`ifdef MEM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;
  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_cnt == '1) state_nxt = READY;
  end

  always_comb begin
    ready_st  = (state == READY);
    clearing  = (state == CLEAR);
    bram_we   = accept & req_we;
    bram_addr = req_addr;
    bram_din  = req_wdata;
    if (state == CLEAR) begin
      bram_we   = rsta_n;
      bram_addr = clr_cnt;
      bram_din  = '0;
    end
  end
`else
  assign ready_st  = 1'b1;
  assign clearing  = 1'b0;
  assign bram_we   = accept & req_we;
  assign bram_addr = req_addr;
  assign bram_din  = req_wdata;
`endif

endmodule
